// File: rtl/imem_loader_if.sv
// Host-side bundle for the instruction-memory loader: byte stream in,
// instruction-memory write port and core-control status out.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    // Load request and program byte stream
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;

    // Instruction-memory write port
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Core control and status
    logic              proc_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start,
        output num_words,
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  proc_hold,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  num_words,
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output proc_hold,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: packs a big-endian byte stream into
// 32-bit words, writes them to consecutive addresses, then releases the core.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic          CLK,
    input  logic          RST,
    imem_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W:0]   num_words_q;
    logic [ADDR_W-1:0] word_cnt;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              hold_q;
    logic              err_q;

    logic              ready_c;
    logic              we_c;
    logic              busy_c;
    logic              done_c;

    logic              len_ok;
    logic              start_seen;
    logic              byte_take;
    logic              last_byte;
    logic              last_word;

    assign len_ok     = (bus.num_words != '0) && (bus.num_words <= MAX_LEN);
    assign start_seen = (state == IDLE) && bus.start;
    assign byte_take  = (state == RECV) && bus.byte_valid;
    assign last_byte  = (byte_cnt == 2'd3);
    // word_cnt stops at num_words-1, so it never wraps even at the full 2^ADDR_W
    assign last_word  = ({1'b0, word_cnt} == (num_words_q - ONE_LEN));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        we_c      = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && len_ok) begin
                    state_nxt = RECV;
                end
            end
            RECV: begin
                ready_c = 1'b1;
                busy_c  = 1'b1;
                if (bus.byte_valid && last_byte) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                we_c      = 1'b1;
                busy_c    = 1'b1;
                state_nxt = last_word ? DONE : RECV;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            num_words_q <= '0;
            word_cnt    <= '0;
            byte_cnt    <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hold_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            if (start_seen) begin
                if (len_ok) begin
                    num_words_q <= bus.num_words;
                    word_cnt    <= '0;
                    byte_cnt    <= '0;
                    err_q       <= 1'b0;
                    hold_q      <= 1'b1;
                end else begin
                    err_q       <= 1'b1;
                end
            end

            // The 4th byte goes straight into the write register, so only
            // three bytes ever need to be buffered.
            if (byte_take) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift_q  <= {shift_q[15:0], bus.byte_data};
                if (last_byte) begin
                    addr_q  <= word_cnt;
                    wdata_q <= {shift_q, bus.byte_data};
                end
            end

            if ((state == WRITE) && !last_word) begin
                word_cnt <= word_cnt + ADDR_W'(1);
            end

            if (state == DONE) begin
                hold_q <= 1'b0;
            end
        end
    end

    assign bus.byte_ready = ready_c;
    assign bus.imem_we    = we_c;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.proc_hold  = hold_q;
    assign bus.err        = err_q;

    a_we_single_cycle: assert property (
        @(posedge CLK) disable iff (RST) bus.imem_we |=> !bus.imem_we);

    a_no_accept_while_writing: assert property (
        @(posedge CLK) disable iff (RST) !(bus.byte_ready && bus.imem_we));

    a_addr_in_range: assert property (
        @(posedge CLK) disable iff (RST)
        bus.imem_we |-> ({1'b0, bus.imem_addr} < num_words_q));

    a_release_after_done: assert property (
        @(posedge CLK) disable iff (RST) bus.done |=> !bus.proc_hold);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: behavioural model compared every cycle,
// plus directed loads with hand-computed instruction words.
module tb_imem_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;

    logic CLK;
    logic RST;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: a load is "active" from accepted start until its last
    // word is written; a write happens the cycle after every 4th byte.
    logic              m_active;
    logic              m_we;
    logic              m_done;
    logic              m_hold;
    logic              m_err;
    int                m_nb;
    logic [31:0]       m_word;
    logic [31:0]       m_data;
    logic [ADDR_W-1:0] m_addr;
    int                m_written;
    int                m_total;

    always @(posedge CLK) begin
        if (RST) begin
            m_active  <= 1'b0;
            m_we      <= 1'b0;
            m_done    <= 1'b0;
            m_hold    <= 1'b1;
            m_err     <= 1'b0;
            m_nb      <= 0;
            m_word    <= '0;
            m_data    <= '0;
            m_addr    <= '0;
            m_written <= 0;
            m_total   <= 0;
        end else begin
            m_we   <= 1'b0;
            m_done <= 1'b0;
            if (m_done) m_hold <= 1'b0;
            if (!m_active && !m_done && bus.start) begin
                if (int'(bus.num_words) >= 1 && int'(bus.num_words) <= MAX_WORDS) begin
                    m_active  <= 1'b1;
                    m_total   <= int'(bus.num_words);
                    m_written <= 0;
                    m_nb      <= 0;
                    m_err     <= 1'b0;
                    m_hold    <= 1'b1;
                end else begin
                    m_err <= 1'b1;
                end
            end
            if (m_active && !m_we && bus.byte_valid) begin
                m_word <= {m_word[23:0], bus.byte_data};
                if (m_nb == 3) begin
                    m_nb   <= 0;
                    m_we   <= 1'b1;
                    m_addr <= ADDR_W'(m_written);
                    m_data <= {m_word[23:0], bus.byte_data};
                end else begin
                    m_nb <= m_nb + 1;
                end
            end
            if (m_we) begin
                m_written <= m_written + 1;
                if (m_written + 1 == m_total) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end
            end
        end
    end

    // Write log of what the DUT actually strobed into instruction memory
    logic [31:0]       wr_mem [MAX_WORDS];
    int                wr_cnt    = 0;
    int                done_cnt  = 0;
    int                clash_cnt = 0;
    logic [ADDR_W-1:0] wr_last   = '0;

    always @(posedge CLK) begin
        if (bus.imem_we === 1'b1) begin
            wr_mem[bus.imem_addr] <= bus.imem_wdata;
            wr_cnt                <= wr_cnt + 1;
            wr_last               <= bus.imem_addr;
        end
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.imem_we === 1'b1 && bus.byte_ready === 1'b1) clash_cnt <= clash_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("byte_ready", 64'(bus.byte_ready), 64'(m_active && !m_we));
        check("imem_we",    64'(bus.imem_we),    64'(m_we));
        check("imem_addr",  64'(bus.imem_addr),  64'(m_addr));
        check("imem_wdata", 64'(bus.imem_wdata), 64'(m_data));
        check("proc_hold",  64'(bus.proc_hold),  64'(m_hold));
        check("busy",       64'(bus.busy),       64'(m_active));
        check("done",       64'(bus.done),       64'(m_done));
        check("err",        64'(bus.err),        64'(m_err));
    endtask

    // One clock: compare on the falling edge, return 1 time unit after the rise
    task automatic tick();
        @(negedge CLK);
        compare_outputs();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input int n);
        bus.start     = 1'b1;
        bus.num_words = (ADDR_W + 1)'(n);
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            bus.byte_valid = 1'b0;
            tick();
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("byte_ready_timeout", 64'(1), 64'(0));
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        logic [31:0] sh;
        sh = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(sh[31:24], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            sh = sh << 8;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check("idle_timeout", 64'(1), 64'(0));
    endtask

    function automatic logic [31:0] full_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'h5a, 8'hc3};
    endfunction

    logic [31:0] three_words [3];
    int          w0;
    int          d0;

    initial begin
        three_words[0] = 32'h00010820;
        three_words[1] = 32'h20010008;
        three_words[2] = 32'h80200000;

        RST            = 1'b1;
        bus.start      = 1'b0;
        bus.num_words  = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;

        // Reset values
        tick();
        tick();
        check("rst_proc_hold",  64'(bus.proc_hold),  64'(1));
        check("rst_byte_ready", 64'(bus.byte_ready), 64'(0));
        check("rst_imem_we",    64'(bus.imem_we),    64'(0));
        check("rst_imem_addr",  64'(bus.imem_addr),  64'(0));
        check("rst_imem_wdata", 64'(bus.imem_wdata), 64'(0));
        check("rst_busy",       64'(bus.busy),       64'(0));
        check("rst_done",       64'(bus.done),       64'(0));
        check("rst_err",        64'(bus.err),        64'(0));
        RST = 1'b0;
        tick();

        // Single word, back-to-back bytes
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(1);
        check("start_to_ready", 64'(bus.byte_ready), 64'(1));
        send_word(32'h20010008, 0);
        check("single_we",      64'(bus.imem_we),    64'(1));
        check("single_addr",    64'(bus.imem_addr),  64'(0));
        check("single_data",    64'(bus.imem_wdata), 64'h20010008);
        check("model_data",     64'(m_data),         64'h20010008);
        tick();
        check("single_done",    64'(bus.done),       64'(1));
        check("single_hold_dn", 64'(bus.proc_hold),  64'(1));
        tick();
        check("single_release", 64'(bus.proc_hold),  64'(0));
        check("single_writes",  64'(wr_cnt - w0),    64'(1));
        check("single_mem0",    64'(wr_mem[0]),      64'h20010008);
        check("single_dones",   64'(done_cnt - d0),  64'(1));

        // Three words with random valid gaps
        w0 = wr_cnt;
        do_start(3);
        for (int i = 0; i < 3; i++) send_word(three_words[i], 3);
        wait_idle();
        tick();
        check("three_writes",   64'(wr_cnt - w0),    64'(3));
        check("three_mem0",     64'(wr_mem[0]),      64'h00010820);
        check("three_mem1",     64'(wr_mem[1]),      64'h20010008);
        check("three_mem2",     64'(wr_mem[2]),      64'h80200000);
        check("three_last",     64'(wr_last),        64'(2));
        check("no_ready_in_wr", 64'(clash_cnt),      64'(0));

        // Illegal lengths, then a legal start clears err
        w0 = wr_cnt;
        do_start(0);
        tick();
        check("len0_err",       64'(bus.err),        64'(1));
        check("len0_busy",      64'(bus.busy),       64'(0));
        check("len0_hold",      64'(bus.proc_hold),  64'(0));
        do_start(MAX_WORDS + 1);
        tick();
        check("len257_err",     64'(bus.err),        64'(1));
        check("len257_ready",   64'(bus.byte_ready), 64'(0));
        check("illegal_writes", 64'(wr_cnt - w0),    64'(0));
        do_start(1);
        check("legal_clr_err",  64'(bus.err),        64'(0));
        check("legal_hold",     64'(bus.proc_hold),  64'(1));
        send_word(32'h8c020004, 0);
        wait_idle();
        tick();
        check("legal_mem0",     64'(wr_mem[0]),      64'h8c020004);

        // Reset after two bytes of the second word
        w0 = wr_cnt;
        do_start(2);
        send_word(32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_hold",   64'(bus.proc_hold),  64'(1));
        check("mid_rst_busy",   64'(bus.busy),       64'(0));
        check("mid_rst_addr",   64'(bus.imem_addr),  64'(0));
        check("mid_rst_writes", 64'(wr_cnt - w0),    64'(1));
        do_start(1);
        send_word(32'haabbccdd, 1);
        wait_idle();
        tick();
        check("restart_mem0",   64'(wr_mem[0]),      64'haabbccdd);
        check("restart_writes", 64'(wr_cnt - w0),    64'(2));
        check("restart_last",   64'(wr_last),        64'(0));

        // Full 256-word program with a start pulse while busy
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(MAX_WORDS);
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (i == 10) begin
                bus.start     = 1'b1;
                bus.num_words = (ADDR_W + 1)'(1);
                tick();
                bus.start     = 1'b0;
            end
            send_word(full_word(i), 0);
        end
        wait_idle();
        tick();
        check("full_writes",    64'(wr_cnt - w0),    64'(256));
        check("full_last_addr", 64'(wr_last),        64'h00ff);
        check("full_dones",     64'(done_cnt - d0),  64'(1));
        check("full_mem0",      64'(wr_mem[0]),      64'h00ff5ac3);
        check("full_mem128",    64'(wr_mem[128]),    64'(full_word(128)));
        check("full_mem255",    64'(wr_mem[255]),    64'hff00a5c3);
        check("full_err",       64'(bus.err),        64'(0));
        check("full_release",   64'(bus.proc_hold),  64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the pipelined MIPS core: it accepts a byte stream of big-endian machine code, assembles 32-bit instruction words, and writes them to consecutive word addresses of the instruction memory, which the core's fetch stage reads. While loading, it holds the core idle through `proc_hold`, then releases it, so a bench or host can inject programs instead of hard-coding them.

## Interface

**Parameters**
- `ADDR_W`, default 8: instruction-memory word-address width.
- `MAX_WORDS`, default 256: largest legal program length in words; must be ≤ 2^ADDR_W.

**Ports**
- `CLK`, in, 1: the single clock; all state updates on the rising edge.
- `RST`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: request a load; sampled only in IDLE.
- `num_words`, in, ADDR_W+1: program length in words; latched when `start` is accepted.
- `byte_valid`, in, 1: `byte_data` is valid.
- `byte_data`, in, 8: next program byte.
- `byte_ready`, out, 1: loader accepts a byte this cycle.
- `imem_we`, out, 1: instruction-memory write strobe.
- `imem_addr`, out, ADDR_W: word address to write.
- `imem_wdata`, out, 32: instruction word to write.
- `proc_hold`, out, 1: holds the core in reset/stall while 1.
- `busy`, out, 1: a load is in progress (RECV or WRITE).
- `done`, out, 1: one-cycle pulse when the load completes.
- `err`, out, 1: last `start` was rejected; sticky.

## Operation

- **States:** IDLE, RECV, WRITE, DONE.
- **IDLE:** `byte_ready`=0, `busy`=0.
  - On `start`=1 with 1 ≤ `num_words` ≤ MAX_WORDS: latch `num_words`, clear `word_cnt`, `byte_cnt` and `err`, set `proc_hold`=1, go to RECV.
  - On `start`=1 with an illegal `num_words`: set `err`=1 and stay in IDLE. `proc_hold` is unchanged.
- **RECV:** `byte_ready`=1.
  - A byte is accepted on a rising edge where `byte_valid` and `byte_ready` are both 1.
  - The accepted byte is shifted in MSB-first: the first byte lands in word[31:24] and the fourth in word[7:0]. `byte_cnt` increments modulo 4.
  - When the 4th byte is accepted, go to WRITE.
- **WRITE:** `byte_ready`=0, `imem_we`=1 for exactly one cycle, `imem_addr`=`word_cnt`, `imem_wdata`=assembled word.
  - If `word_cnt` = latched `num_words`−1, go to DONE. Otherwise increment `word_cnt` and go to RECV.
- **DONE:** `done`=1 for one cycle, `proc_hold` goes to 0 at the end of that cycle, then go to IDLE.
- `start` is ignored in every state except IDLE.
- Bytes presented outside RECV are not accepted, because `byte_ready`=0.
- `imem_addr` and `imem_wdata` hold their last values when `imem_we`=0. Their values are don't-care but stable.

## Timing

- **Reset values:** state=IDLE, `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `proc_hold`=1, `busy`=0, `done`=0, `err`=0. The core stays held until the first successful load.
- **Reset mid-load:** RST in any state returns to IDLE on that edge with the reset values above. A partially assembled word is discarded. Words already written remain in memory.
- **`start` to RECV:** `byte_ready`=1 in the cycle after `start` is sampled.
- **4th byte to write:** `imem_we`=1 in the cycle immediately after the edge that accepts the 4th byte.
- **Throughput:** maximum is one word per 5 cycles (4 byte cycles plus 1 write cycle). `byte_valid` gaps stall without loss.
- **Last write to completion:** `done`=1 in the cycle after the final WRITE cycle, and `proc_hold`=0 from the following cycle.
- **`busy`:** 1 exactly while in RECV or WRITE.
- **Address range:** at `num_words`=MAX_WORDS=2^ADDR_W, the final `imem_addr` is 2^ADDR_W−1. `word_cnt` never wraps past that.

## Test plan

- **Reset:** hold RST for 2 cycles → every output matches its reset value, including `proc_hold`=1.
- **Single word:** `num_words`=1; send bytes 0x20, 0x01, 0x00, 0x08 back-to-back → one `imem_we` pulse with addr 0 and data 0x20010008, one cycle later `done`=1, then `proc_hold`=0.
- **Three words with gaps:** `num_words`=3 with random `byte_valid` gaps; words 0x00010820, 0x20010008, 0x80200000 → exactly 3 writes at addresses 0, 1, 2 with those data values, and `byte_ready`=0 during each WRITE.
- **Illegal lengths:** `start` with `num_words`=0, then with MAX_WORDS+1 → `err`=1, no writes, state stays IDLE. A following legal `start` clears `err`.
- **Reset mid-load:** RST after 2 bytes of word 1 → IDLE with `proc_hold`=1. A restarted 1-word load writes address 0 with the correct data.
- **Full length:** `num_words`=256 with ADDR_W=8, and `start` pulsed while busy → exactly 256 writes with the last address 0xFF, the mid-load `start` is ignored, and a single `done` pulse.
